// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite response codes and register-bank FSM state types.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

endpackage

// File: rtl/axi_lite_addr_dec.sv
// Maps a byte address onto a register index; flags addresses outside the bank.
module axi_lite_addr_dec #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'hFFFF_0000),
  parameter int unsigned           STRB_WIDTH = 4,
  parameter int unsigned           NUM_REGS   = 8,
  localparam int unsigned          IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  hit_c_o,
  output logic [IDX_W-1:0]      idx_c_o
);

  localparam int unsigned LSB_W = $clog2(STRB_WIDTH);

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] word;

  // Byte offset from the bank base, then word index; sub-word bits drop out in the shift.
  always_comb begin
    offset  = addr_i - BASE_ADDR;
    word    = offset >> LSB_W;
    hit_c_o = (addr_i >= BASE_ADDR) && (word < ADDR_WIDTH'(NUM_REGS));
    idx_c_o = IDX_W'(word);
  end

endmodule

// File: rtl/axi_lite_regbank.sv
// AXI-Lite slave register bank with per-register read-only mask and write strobes.
module axi_lite_regbank
  import axi_lite_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'hFFFF_0000),
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned           NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0
) (
  input  logic                           aclk,
  input  logic                           arst,
  input  logic                           awvalid,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  output logic                           awready,
  input  logic                           wvalid,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [STRB_WIDTH-1:0]          wstrb,
  output logic                           wready,
  input  logic                           bready,
  output logic                           bvalid,
  output logic [1:0]                     bresp,
  input  logic                           arvalid,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  output logic                           arready,
  input  logic                           rready,
  output logic                           rvalid,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  w_state_e              w_state_q;
  r_state_e              r_state_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [NUM_REGS-1:0]   wr_pulse_q;

  logic                  aw_hs_c;
  logic                  ar_hs_c;
  logic                  w_hit_c;
  logic                  r_hit_c;
  logic [IDX_W-1:0]      w_idx_c;
  logic [IDX_W-1:0]      r_idx_c;
  logic [1:0]            w_resp_c;

  // Readies are combinational so a held request is taken in the same cycle (2-cycle throughput).
  assign aw_hs_c = !arst && (w_state_q == W_IDLE) && awvalid && wvalid;
  assign ar_hs_c = !arst && (r_state_q == R_IDLE) && arvalid;

  assign awready    = aw_hs_c;
  assign wready     = aw_hs_c;
  assign arready    = ar_hs_c;
  assign bvalid     = bvalid_q;
  assign bresp      = bresp_q;
  assign rvalid     = rvalid_q;
  assign rresp      = rresp_q;
  assign rdata      = rdata_q;
  assign wr_pulse_o = wr_pulse_q;

  axi_lite_addr_dec #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .STRB_WIDTH (STRB_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_wr_dec (
    .addr_i  (awaddr),
    .hit_c_o (w_hit_c),
    .idx_c_o (w_idx_c)
  );

  axi_lite_addr_dec #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .STRB_WIDTH (STRB_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_rd_dec (
    .addr_i  (araddr),
    .hit_c_o (r_hit_c),
    .idx_c_o (r_idx_c)
  );

  // Write response classification: decode miss beats read-only.
  always_comb begin
    w_resp_c = RESP_OKAY;
    if (!w_hit_c) begin
      w_resp_c = RESP_DECERR;
    end else if (RO_MASK[w_idx_c]) begin
      w_resp_c = RESP_SLVERR;
    end
  end

  // Write channel FSM: accept, then hold the response until bready.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      w_state_q  <= W_IDLE;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      case (w_state_q)
        W_IDLE: begin
          if (aw_hs_c) begin
            w_state_q <= W_RESP;
            bvalid_q  <= 1'b1;
            bresp_q   <= w_resp_c;
            if (w_resp_c == RESP_OKAY) begin
              wr_pulse_q <= NUM_REGS'(1) << w_idx_c;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            w_state_q <= W_IDLE;
            bvalid_q  <= 1'b0;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Register storage: byte-lane merge on an accepted OKAY write.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (aw_hs_c && (w_resp_c == RESP_OKAY)) begin
      for (int unsigned k = 0; k < STRB_WIDTH; k++) begin
        if (wstrb[k]) begin
          regs_q[w_idx_c][k*8 +: 8] <= wdata[k*8 +: 8];
        end
      end
    end
  end

  // Read channel FSM: capture data at acceptance (pre-write value), hold until rready.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_hs_c) begin
            r_state_q <= R_DATA;
            rvalid_q  <= 1'b1;
            rresp_q   <= r_hit_c ? RESP_OKAY : RESP_DECERR;
            rdata_q   <= r_hit_c ? regs_q[r_idx_c] : '0;
          end
        end
        R_DATA: begin
          if (rready) begin
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // Flattened register view.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
    assign regs_o[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
  end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed bench for axi_lite_regbank with a transaction-level reference model.
module tb_axi_lite_regbank;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam int          NREG = 8;
  localparam logic [7:0]  RO   = 8'h01;

  logic         aclk = 1'b0;
  logic         arst;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic [31:0]  awaddr, wdata, araddr;
  logic [3:0]   wstrb;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [255:0] regs_o;
  logic [7:0]   wr_pulse_o;

  int n_total = 0;
  int n_pass  = 0;

  axi_lite_regbank #(
    .ADDR_WIDTH (32),
    .BASE_ADDR  (BASE),
    .DATA_WIDTH (32),
    .STRB_WIDTH (4),
    .NUM_REGS   (NREG),
    .RO_MASK    (RO)
  ) dut (
    .aclk       (aclk),
    .arst       (arst),
    .awvalid    (awvalid),
    .awaddr     (awaddr),
    .awready    (awready),
    .wvalid     (wvalid),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .wready     (wready),
    .bready     (bready),
    .bvalid     (bvalid),
    .bresp      (bresp),
    .arvalid    (arvalid),
    .araddr     (araddr),
    .arready    (arready),
    .rready     (rready),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .rresp      (rresp),
    .regs_o     (regs_o),
    .wr_pulse_o (wr_pulse_o)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] m_regs [NREG];
  bit          m_wbusy, m_rbusy;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata;
  logic [7:0]  m_pulse;
  bit          m_ok;
  int          m_idx;

  function automatic void m_decode(input logic [31:0] addr, output bit ok, output int idx);
    logic [31:0] off;
    off = addr - BASE;
    idx = int'(off / 4);
    ok  = (addr >= BASE) && (idx < NREG);
    if (!ok) idx = 0;
  endfunction

  function automatic logic [255:0] m_flat();
    logic [255:0] f;
    f = '0;
    for (int i = 0; i < NREG; i++) f[i*32 +: 32] = m_regs[i];
    return f;
  endfunction

  always @(posedge aclk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < NREG; i++) m_regs[i] = 32'h0;
      m_wbusy = 0; m_rbusy = 0;
      m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = 32'h0; m_pulse = 8'h00;
    end else begin
      m_pulse = 8'h00;
      // reads see register contents from before any same-cycle write
      if (m_rbusy) begin
        if (rready) m_rbusy = 0;
      end else if (arvalid) begin
        m_decode(araddr, m_ok, m_idx);
        m_rbusy = 1;
        m_rresp = m_ok ? 2'b00 : 2'b11;
        m_rdata = m_ok ? m_regs[m_idx] : 32'h0;
      end
      if (m_wbusy) begin
        if (bready) m_wbusy = 0;
      end else if (awvalid && wvalid) begin
        m_decode(awaddr, m_ok, m_idx);
        m_wbusy = 1;
        if (!m_ok) m_bresp = 2'b11;
        else if (RO[m_idx]) m_bresp = 2'b10;
        else begin
          m_bresp = 2'b00;
          for (int k = 0; k < 4; k++)
            if (wstrb[k]) m_regs[m_idx][k*8 +: 8] = wdata[k*8 +: 8];
          m_pulse = 8'(1) << m_idx;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge aclk) begin
    if (!arst) begin
      chk("awready", 256'(awready), 256'(!m_wbusy && awvalid && wvalid));
      chk("wready",  256'(wready),  256'(!m_wbusy && awvalid && wvalid));
      chk("arready", 256'(arready), 256'(!m_rbusy && arvalid));
      chk("bvalid",  256'(bvalid),  256'(m_wbusy));
      chk("rvalid",  256'(rvalid),  256'(m_rbusy));
      if (m_wbusy) chk("bresp", 256'(bresp), 256'(m_bresp));
      if (m_rbusy) begin
        chk("rresp", 256'(rresp), 256'(m_rresp));
        chk("rdata", 256'(rdata), 256'(m_rdata));
      end
      chk("wr_pulse", 256'(wr_pulse_o), 256'(m_pulse));
      chk("regs", regs_o, m_flat());
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output logic [7:0] pulse);
    int t;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1; wvalid = 1; bready = 1;
    t = 0;
    @(negedge aclk);
    while (!awready && t < 20) begin @(negedge aclk); t++; end
    chk("aw_accept", 256'(awready), 256'(1'b1));
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0;
    @(negedge aclk);
    resp = bresp; pulse = wr_pulse_o;
    @(posedge aclk); #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold,
                         output logic [31:0] data, output logic [1:0] resp);
    int t;
    araddr = addr; arvalid = 1; rready = (hold == 0);
    t = 0;
    @(negedge aclk);
    while (!arready && t < 20) begin @(negedge aclk); t++; end
    chk("ar_accept", 256'(arready), 256'(1'b1));
    @(posedge aclk); #1;
    arvalid = 0;
    @(negedge aclk);
    data = rdata; resp = rresp;
    if (hold > 0) begin
      repeat (hold) @(posedge aclk);
      #1 rready = 1;
    end
    @(posedge aclk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [7:0]  pulse;
    logic [31:0] data;
    int          acc;

    arst = 0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
    #2 arst = 1;
    #1 awvalid = 1; wvalid = 1; arvalid = 1;
    #1;
    chk("rst_awready", 256'(awready), 256'(0));
    chk("rst_arready", 256'(arready), 256'(0));
    chk("rst_bvalid", 256'(bvalid), 256'(0));
    chk("rst_rvalid", 256'(rvalid), 256'(0));
    chk("rst_rdata", 256'(rdata), 256'(0));
    chk("rst_resps", 256'({bresp, rresp}), 256'(0));
    chk("rst_pulse", 256'(wr_pulse_o), 256'(0));
    chk("rst_regs", regs_o, 256'(0));
    awvalid = 0; wvalid = 0; arvalid = 0;
    repeat (2) @(posedge aclk);
    #1 arst = 0;

    // full-word write and read back of reg 3
    do_write(BASE + 32'hC, 32'hDEADBEEF, 4'b1111, resp, pulse);
    chk("w3_bresp", 256'(resp), 256'(2'b00));
    chk("w3_pulse", 256'(pulse), 256'(8'h08));
    do_read(BASE + 32'hC, 0, data, resp);
    chk("r3_rdata", 256'(data), 256'(32'hDEADBEEF));
    chk("r3_rresp", 256'(resp), 256'(2'b00));

    // sub-word address bits ignored
    do_read(BASE + 32'hF, 0, data, resp);
    chk("r3_unaligned", 256'(data), 256'(32'hDEADBEEF));

    // partial strobe into reg 2
    do_write(BASE + 32'h8, 32'hDEADBEEF, 4'b0101, resp, pulse);
    chk("w2_pulse", 256'(pulse), 256'(8'h04));
    do_read(BASE + 32'h8, 3, data, resp);
    chk("r2_rdata", 256'(data), 256'(32'h00AD00EF));

    // past the top of the bank and below the base
    do_write(BASE + 32'h20, 32'h12345678, 4'b1111, resp, pulse);
    chk("wdec_bresp", 256'(resp), 256'(2'b11));
    chk("wdec_pulse", 256'(pulse), 256'(8'h00));
    do_read(BASE + 32'h20, 0, data, resp);
    chk("rdec_rresp", 256'(resp), 256'(2'b11));
    chk("rdec_rdata", 256'(data), 256'(0));
    do_read(BASE - 32'h4, 0, data, resp);
    chk("rlow_rresp", 256'(resp), 256'(2'b11));

    // read-only reg 0
    do_write(BASE, 32'hFFFFFFFF, 4'b1111, resp, pulse);
    chk("wro_bresp", 256'(resp), 256'(2'b10));
    chk("wro_pulse", 256'(pulse), 256'(8'h00));
    do_read(BASE, 0, data, resp);
    chk("rro_rdata", 256'(data), 256'(0));
    chk("rro_rresp", 256'(resp), 256'(2'b00));

    // zero strobe: OKAY, pulse, no change
    do_write(BASE + 32'h10, 32'hCAFEF00D, 4'b0000, resp, pulse);
    chk("wz_bresp", 256'(resp), 256'(2'b00));
    chk("wz_pulse", 256'(pulse), 256'(8'h10));

    // same-cycle read and write of reg 5
    do_write(BASE + 32'h14, 32'h1, 4'b1111, resp, pulse);
    awaddr = BASE + 32'h14; wdata = 32'h2; wstrb = 4'b1111;
    awvalid = 1; wvalid = 1; bready = 1;
    araddr = BASE + 32'h14; arvalid = 1; rready = 1;
    @(negedge aclk);
    chk("same_accept", 256'({awready, arready}), 256'(2'b11));
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(negedge aclk);
    chk("same_rdata", 256'(rdata), 256'(32'h1));
    @(posedge aclk); #1;
    do_read(BASE + 32'h14, 0, data, resp);
    chk("after_rdata", 256'(data), 256'(32'h2));

    // back-to-back writes with everything held high
    awaddr = BASE + 32'h4; wdata = 32'hA5A5A5A5; wstrb = 4'b1111;
    awvalid = 1; wvalid = 1; bready = 1;
    acc = 0;
    repeat (6) begin
      @(negedge aclk);
      if (awready) acc++;
    end
    chk("b2b_accepts", 256'(acc), 256'(3));
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0;
    repeat (2) @(posedge aclk);
    #1;

    // stalled response, then reset mid-transaction
    awaddr = BASE + 32'h18; wdata = 32'h55; wstrb = 4'b1111;
    awvalid = 1; wvalid = 1; bready = 0;
    @(negedge aclk);
    chk("stall_accept", 256'(awready), 256'(1'b1));
    @(posedge aclk); #1;
    awaddr = BASE + 32'h1C; wdata = 32'h77;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      chk("stall_bvalid", 256'(bvalid), 256'(1'b1));
      chk("stall_awready", 256'(awready), 256'(1'b0));
    end
    @(posedge aclk); #2;
    arst = 1;
    #1;
    chk("arst_bvalid", 256'(bvalid), 256'(0));
    chk("arst_regs", regs_o, 256'(0));
    chk("arst_pulse", 256'(wr_pulse_o), 256'(0));
    awvalid = 0; wvalid = 0;
    repeat (2) @(posedge aclk);
    #1 arst = 0;
    repeat (3) begin
      @(negedge aclk);
      chk("post_rst_bvalid", 256'(bvalid), 256'(0));
    end
    do_read(BASE + 32'h18, 0, data, resp);
    chk("post_rst_r6", 256'(data), 256'(0));

    repeat (2) @(posedge aclk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_lite_regbank.md
AXI_LITE_REGBANK -- requirements
Module: axi_lite_regbank

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hFFFF_0000, byte address of register 0.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, register and bus width; legal values are 32 and 64.
REQ-004 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, byte strobes per beat.
REQ-005 SHALL have parameter NUM_REGS, default 8, register count; legal range is 1..256.
REQ-006 SHALL have parameter RO_MASK, default all zeros, NUM_REGS bits; bit i set makes register i read-only.
REQ-007 SHALL have ports aclk input 1 (clock); arst input 1 (reset). One clock; reset is asynchronous and active-high.
REQ-008 SHALL have ports awvalid in 1, awaddr in ADDR_WIDTH, awready out 1: write address channel.
REQ-009 SHALL have ports wvalid in 1, wdata in DATA_WIDTH, wstrb in STRB_WIDTH, wready out 1: write data channel.
REQ-010 SHALL have ports bready in 1, bvalid out 1, bresp out 2: write response channel.
REQ-011 SHALL have ports arvalid in 1, araddr in ADDR_WIDTH, arready out 1: read address channel.
REQ-012 SHALL have ports rready in 1, rvalid out 1, rdata out DATA_WIDTH, rresp out 2: read data channel.
REQ-013 SHALL have port regs_o out NUM_REGS*DATA_WIDTH: flattened register contents, register i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-014 SHALL have port wr_pulse_o out NUM_REGS: one-cycle one-hot strobe for each committed write.

Function
REQ-015 Write FSM SHALL have states W_IDLE and W_RESP.
REQ-016 In W_IDLE with awvalid and wvalid both high, the block SHALL pulse awready and wready together for one cycle, commit the write in that cycle, and move to W_RESP.
REQ-017 In W_IDLE with only one of awvalid or wvalid high, the block SHALL keep both readies low and accept nothing.
REQ-018 In W_RESP, bvalid SHALL be high and held until bready; on the bvalid&&bready cycle the FSM SHALL return to W_IDLE, and readies SHALL stay low while in W_RESP.
REQ-019 Address decode: offset = addr - BASE_ADDR; index = offset / STRB_WIDTH; addr[log2(STRB_WIDTH)-1:0] SHALL be ignored.
REQ-020 An address below BASE_ADDR or with index >= NUM_REGS SHALL give response DECERR (2'b11), no state change, rdata = 0.
REQ-021 A write to a register with its RO_MASK bit set SHALL give SLVERR (2'b10) and no change; reads of that register SHALL return OKAY.
REQ-022 A legal write SHALL update byte lane k only where wstrb[k]=1; wstrb = 0 SHALL be OKAY with no change, but wr_pulse_o SHALL still pulse.
REQ-023 wr_pulse_o[index] SHALL be high exactly in the cycle after commit, for OKAY writes only.
REQ-024 Read FSM SHALL have states R_IDLE and R_DATA, independent of the write FSM.
REQ-025 In R_IDLE with arvalid high, the block SHALL pulse arready for one cycle, register rdata and rresp, and move to R_DATA.
REQ-026 In R_DATA, rvalid SHALL be high with rdata and rresp stable until rready; the FSM SHALL then return to R_IDLE.
REQ-027 When a read and a write to the same register are accepted in the same cycle, rdata SHALL return the pre-write value.
REQ-028 Minimum latency SHALL be one cycle from acceptance to bvalid or rvalid; with valids and readies held high, the throughput is one transaction per 2 cycles per channel.

Reset
REQ-029 arst SHALL force, asynchronously: both FSMs to idle; awready, wready, arready, bvalid, rvalid = 0; bresp, rresp, rdata = 0; all registers = 0; wr_pulse_o = 0.
REQ-030 Reset asserted mid-transaction SHALL drop the pending response with no bvalid or rvalid afterwards; a write accepted in the same cycle as reset SHALL NOT commit.

Structure
REQ-031 A shared package axi_lite_pkg SHALL hold the response codes (OKAY, SLVERR, DECERR) and the FSM state enums.
REQ-032 The address decoder SHALL be one sub-module, axi_lite_addr_dec, instanced once per channel.

Verification
REQ-033 The bench SHALL cover: write 0xDEADBEEF, strobe 4'b1111, to reg 3 (BASE+0xC) -> bresp 00, wr_pulse_o = 8'h08; read reg 3 -> rdata 0xDEADBEEF, rresp 00.
REQ-034 The bench SHALL cover: reg 2 = 0, write 0xDEADBEEF with strobe 4'b0101 -> reading reg 2 gives 0x00AD00EF.
REQ-035 The bench SHALL cover: write and read to BASE+0x20 (NUM_REGS=8) -> bresp 11 and rresp 11 with rdata 0; no register changes.
REQ-036 The bench SHALL cover: RO_MASK = 8'h01, write reg 0 -> bresp 10, reg 0 stays 0, no wr_pulse_o.
REQ-037 The bench SHALL cover: reg 5 = 0x1, same-cycle write 0x2 and read of reg 5 -> rdata 0x1; a subsequent read gives 0x2.
REQ-038 The bench SHALL cover: bready held low for 10 cycles -> bvalid held for those cycles and no further write accepted; then assert arst -> bvalid 0 immediately and all registers 0.
